// File: rtl/toycore_pkg.sv
`default_nettype none
// toycore_pkg -- shared widths, the common-data-bus record and round-robin helper. Rev 1.0
package toycore_pkg;

  localparam int CDB_DATAW = 32;
  localparam int CDB_TAGW  = 6;

  typedef struct packed {
    logic                 en;
    logic [CDB_TAGW-1:0]  tag;
    logic [CDB_DATAW-1:0] value;
  } cdb_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// cdb_arbiter_if -- requester handshake bundle plus the broadcast common data bus. Rev 1.0
interface cdb_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DATAW = toycore_pkg::CDB_DATAW,
  parameter int TAGW  = toycore_pkg::CDB_TAGW
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*TAGW-1:0]  req_tag;
  logic [NREQ*DATAW-1:0] req_value;
  logic [NREQ-1:0]       req_ready;
  logic                  cdb_en;
  logic [TAGW-1:0]       cdb_tag;
  logic [DATAW-1:0]      cdb_value;

  modport master (
    output req_valid, req_tag, req_value,
    input  req_ready, cdb_en, cdb_tag, cdb_value
  );

  modport slave (
    input  req_valid, req_tag, req_value,
    output req_ready, cdb_en, cdb_tag, cdb_value
  );

endinterface
`default_nettype wire

// File: rtl/cdb_rr_pick.sv
`default_nettype none
// cdb_rr_pick -- combinational round-robin pick: first request at or after rr_ptr, wrapping. Rev 1.0
module cdb_rr_pick #(
  parameter int NREQ = 4,
  parameter int PTRW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [PTRW-1:0] grant_idx,
  output logic            any_grant
);

  localparam logic [PTRW:0] NREQ_W = (PTRW+1)'(NREQ);

  logic [PTRW:0]   sum;
  logic [PTRW-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = '0;
    sel       = '0;
    // lowest priority first so the highest-priority hit is the last write
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (PTRW+1)'(k);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      sel = sum[PTRW-1:0];
      if (req[sel]) begin
        grant      = '0;
        grant[sel] = 1'b1;
        grant_idx  = sel;
        any_grant  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// cdb_arbiter -- round-robin result-bus arbiter driving a registered CDB; skid buffer via CDB_ARB_SKID_EN. Rev 1.0
module cdb_arbiter
  import toycore_pkg::*;
#(
  parameter int DATAW = CDB_DATAW,
  parameter int TAGW  = CDB_TAGW,
  parameter int NREQ  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);

  localparam int PTRW = $clog2(NREQ);

  logic [PTRW-1:0] rr_ptr;
  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] pick_grant;
  logic [PTRW-1:0] pick_ptr;
  logic [PTRW-1:0] pick_idx;
  logic            pick_any;

  function automatic logic [PTRW-1:0] ptr_after(input logic [PTRW-1:0] idx);
    return PTRW'(rr_next({{(32-PTRW){1'b0}}, idx}, NREQ));
  endfunction

  cdb_rr_pick #(.NREQ(NREQ), .PTRW(PTRW)) u_pick (
    .req       (pick_req),
    .rr_ptr    (pick_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_grant (pick_any)
  );

`ifdef CDB_ARB_SKID_EN
  logic [NREQ-1:0]  ent_v;
  logic [NREQ-1:0]  ent_v_nxt;
  logic [NREQ-1:0]  grant_r;
  logic [NREQ-1:0]  ready_r;
  logic [NREQ-1:0]  accept;
  logic [TAGW-1:0]  ent_tag   [NREQ];
  logic [DATAW-1:0] ent_value [NREQ];
  logic [PTRW-1:0]  grant_idx_r;
  logic [PTRW-1:0]  rr_ptr_nxt;
  logic             any_r;

  assign bus.req_ready = ready_r & {NREQ{rst_n}};
  assign accept        = bus.req_valid & bus.req_ready;
  assign ent_v_nxt     = accept | (ent_v & ~grant_r);
  assign rr_ptr_nxt    = any_r ? ptr_after(grant_idx_r) : rr_ptr;

  // Pick one cycle ahead on next-state entries so grant and ready both leave flops.
  assign pick_req = ent_v_nxt;
  assign pick_ptr = rr_ptr_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_v         <= '0;
      grant_r       <= '0;
      grant_idx_r   <= '0;
      any_r         <= 1'b0;
      ready_r       <= '1;
      rr_ptr        <= '0;
      bus.cdb_en    <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_value <= '0;
    end else begin
      ent_v       <= ent_v_nxt;
      grant_r     <= pick_grant;
      grant_idx_r <= pick_idx;
      any_r       <= pick_any;
      ready_r     <= ~ent_v_nxt | pick_grant;
      rr_ptr      <= rr_ptr_nxt;
      bus.cdb_en  <= any_r;
      if (any_r) begin
        bus.cdb_tag   <= ent_tag[grant_idx_r];
        bus.cdb_value <= ent_value[grant_idx_r];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        ent_tag[i]   <= bus.req_tag[i*TAGW +: TAGW];
        ent_value[i] <= bus.req_value[i*DATAW +: DATAW];
      end
    end
  end
`else
  assign pick_req      = bus.req_valid;
  assign pick_ptr      = rr_ptr;
  assign bus.req_ready = pick_grant & {NREQ{rst_n}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      bus.cdb_en    <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_value <= '0;
    end else begin
      bus.cdb_en <= pick_any;
      if (pick_any) begin
        rr_ptr        <= ptr_after(pick_idx);
        bus.cdb_tag   <= bus.req_tag[int'(pick_idx)*TAGW +: TAGW];
        bus.cdb_value <= bus.req_value[int'(pick_idx)*DATAW +: DATAW];
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// tb_cdb_arbiter -- directed and random stimulus checked against a transaction-level arbiter model.
module tb_cdb_arbiter;
  import toycore_pkg::*;

  localparam int NREQ  = 4;
  localparam int DATAW = CDB_DATAW;
  localparam int TAGW  = CDB_TAGW;
`ifdef CDB_ARB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NREQ(NREQ), .DATAW(DATAW), .TAGW(TAGW)) bus ();

  cdb_arbiter #(.DATAW(DATAW), .TAGW(TAGW), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // requester-side drive state
  logic [NREQ-1:0]  drv_v;
  logic [TAGW-1:0]  drv_tag [NREQ];
  logic [DATAW-1:0] drv_val [NREQ];
  logic [NREQ-1:0]  xfer;

  // reference model: pointer, expected bus, and one holding slot per requester
  int               m_ptr;
  cdb_t             m_cdb;
  bit               m_slot_v   [NREQ];
  logic [TAGW-1:0]  m_slot_tag [NREQ];
  logic [DATAW-1:0] m_slot_val [NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req_valid = drv_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_tag[i*TAGW +: TAGW]    = drv_tag[i];
      bus.req_value[i*DATAW +: DATAW] = drv_val[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_cdb = '0;
    for (int i = 0; i < NREQ; i++) m_slot_v[i] = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] exp_ready;
    int w;
    apply();
    @(negedge clk);
    cand = '0;
    for (int i = 0; i < NREQ; i++) cand[i] = SKID ? m_slot_v[i] : drv_v[i];
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (w < 0 && cand[j]) w = j;
    end
    exp_ready = '0;
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++)
        exp_ready[i] = SKID ? (!m_slot_v[i] || w == i) : (w == i);
    end
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("cdb_en",    64'(bus.cdb_en),    64'(m_cdb.en));
    check("cdb_tag",   64'(bus.cdb_tag),   64'(m_cdb.tag));
    check("cdb_value", 64'(bus.cdb_value), 64'(m_cdb.value));
    @(posedge clk);
    for (int i = 0; i < NREQ; i++) xfer[i] = rst_n && drv_v[i] && exp_ready[i];
    if (!rst_n) begin
      model_reset();
    end else begin
      if (w >= 0) begin
        m_cdb.en    = 1'b1;
        m_cdb.tag   = SKID ? m_slot_tag[w] : drv_tag[w];
        m_cdb.value = SKID ? m_slot_val[w] : drv_val[w];
        m_ptr       = (w + 1) % NREQ;
        m_slot_v[w] = 1'b0;
      end else begin
        m_cdb.en = 1'b0;
      end
      if (SKID) begin
        for (int i = 0; i < NREQ; i++) begin
          if (xfer[i]) begin
            m_slot_v[i]   = 1'b1;
            m_slot_tag[i] = drv_tag[i];
            m_slot_val[i] = drv_val[i];
          end
        end
      end
    end
    #1;
  endtask

  task automatic wait_xfer(input int idx);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      cycle();
      done = xfer[idx];
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL accept_timeout: requester %0d observed no transfer expected one within 10 cycles", idx);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drv_v = '1;
    xfer  = '0;
    for (int i = 0; i < NREQ; i++) begin
      drv_tag[i] = TAGW'(i + 1);
      drv_val[i] = $urandom;
    end
    model_reset();
    apply();
    @(posedge clk);
    #1;

    // reset with every requester valid, then idle
    repeat (3) cycle();
    rst_n = 1'b1;
    drv_v = '0;
    repeat (3) cycle();

    // single request from requester 2
    drv_v[2]   = 1'b1;
    drv_tag[2] = 6'h15;
    drv_val[2] = 32'hDEADBEEF;
    wait_xfer(2);
    drv_v = '0;
    repeat (3) cycle();

    // full contention, same tags re-presented after each accept
    for (int i = 0; i < NREQ; i++) drv_tag[i] = TAGW'(i + 1);
    drv_v = '1;
    repeat (12) cycle();
    drv_v = '0;
    repeat (3) cycle();

    // wrap-around: grant 2 moves the pointer to 3, then only 0 and 1 request
    drv_v[2] = 1'b1;
    wait_xfer(2);
    drv_v = 4'b0011;
    for (int n = 0; n < 8; n++) begin
      cycle();
      drv_v &= ~xfer;
    end
    repeat (2) cycle();

    // mid-operation reset with requesters 1 and 3 pending
    drv_v = 4'b1010;
    cycle();
    for (int i = 0; i < NREQ; i++) if (xfer[i]) drv_tag[i] = TAGW'($urandom);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      cycle();
      drv_v &= ~xfer;
    end
    repeat (2) cycle();

`ifdef CDB_ARB_SKID_EN
    // back-to-back stream from requester 0
    drv_v[0]   = 1'b1;
    drv_tag[0] = 6'h10;
    for (int n = 0; n < 8 && drv_v[0]; n++) begin
      cycle();
      if (xfer[0]) begin
        if (drv_tag[0] == 6'h12) drv_v[0] = 1'b0;
        else drv_tag[0] = drv_tag[0] + 6'h01;
      end
    end
    repeat (3) cycle();
`endif

    // random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      cycle();
      rst_n = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!drv_v[i] || xfer[i]) begin
          drv_v[i]   = ($urandom_range(0, 3) != 0);
          drv_tag[i] = TAGW'($urandom);
          drv_val[i] = $urandom;
        end
      end
    end
    rst_n = 1'b1;
    drv_v = '0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
